// File: rtl/jtag_scan_master.sv
// jtag_scan_master: drives single IR/DR scans on a JTAG TAP from a
// valid/ready command and returns the captured TDO bits.
module jtag_scan_master #(
    parameter int TCK_HALF   = 2,
    parameter int TLR_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_ir,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        trst_req,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam int DW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_HALF - 1);
    localparam logic [7:0] TLR_LAST = 8'(TLR_CYCLES);

    typedef enum logic [2:0] {
        TLR,
        IDLE,
        HDR,
        SHIFT,
        TAIL,
        RESP
    } state_t;

    state_t        state_q, state_d;
    state_t        nst;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    cyc_q, cyc_d;
    logic [7:0]    last_cyc;
    logic          tck_q, tck_d;
    logic          tms_q, tms_d;
    logic          tdi_q, tdi_d;
    logic          is_ir_q, is_ir_d;
    logic [5:0]    len_q, len_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          err_q, err_d;
    logic          len_bad;

    // {tms, tdi} to present during TCK cycle c of state st
    function automatic logic [1:0] pin_bits(
        input state_t      st,
        input logic [7:0]  c,
        input logic        ir,
        input logic [5:0]  len,
        input logic [31:0] d
    );
        logic [1:0] b;
        b = 2'b00;
        unique case (st)
            TLR:     b = {c < TLR_LAST, 1'b0};
            HDR:     b = {c < (ir ? 8'd2 : 8'd1), 1'b0};
            SHIFT:   b = {c == ({2'b00, len} - 8'd1), d[c[4:0]]};
            TAIL:    b = {c == 8'd0, 1'b0};
            default: b = 2'b00;
        endcase
        return b;
    endfunction

    // Next-state, TCK divider, pin sequencing and TDO capture
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cyc_d    = cyc_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        is_ir_d  = is_ir_q;
        len_d    = len_q;
        data_d   = data_q;
        rdat_d   = rdat_q;
        err_d    = err_q;
        nst      = state_q;
        last_cyc = 8'd2;
        len_bad  = (cmd_len == 6'd0) || (cmd_len > 6'd32);

        // TAIL never ends on a falling edge: cycle 2 is the extra
        // clk before RESP, handled ahead of the divider below.
        unique case (state_q)
            TLR: begin
                last_cyc = TLR_LAST;
                nst      = IDLE;
            end
            HDR: begin
                last_cyc = is_ir_q ? 8'd3 : 8'd2;
                nst      = SHIFT;
            end
            SHIFT: begin
                last_cyc = {2'b00, len_q} - 8'd1;
                nst      = TAIL;
            end
            default: begin
                last_cyc = 8'd2;
                nst      = state_q;
            end
        endcase

        unique case (state_q)
            IDLE: begin
                if (trst_req) begin
                    state_d = TLR;
                    cyc_d   = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                end else if (cmd_valid) begin
                    is_ir_d = cmd_is_ir;
                    len_d   = cmd_len;
                    data_d  = cmd_data;
                    rdat_d  = '0;
                    err_d   = len_bad;
                    cyc_d   = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    if (len_bad) begin
                        state_d = RESP;
                    end else begin
                        state_d = HDR;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (state_q == TAIL && cyc_q == 8'd2) begin
                    state_d = RESP;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        if (state_q == SHIFT) begin
                            rdat_d[cyc_q[4:0]] = tdo;
                        end
                    end else begin
                        if (cyc_q == last_cyc) begin
                            state_d = nst;
                            cyc_d   = '0;
                        end else begin
                            cyc_d = cyc_q + 8'd1;
                        end
                        {tms_d, tdi_d} = pin_bits(state_d, cyc_d,
                                                  is_ir_q, len_q,
                                                  data_q);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers; reset restarts the TLR walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR;
            div_q   <= '0;
            cyc_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            is_ir_q <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cyc_q   <= cyc_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            is_ir_q <= is_ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !trst_req;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rdat_q;
    assign rsp_err   = err_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule
